perf_sample_unit: RTL and testbench

// - Downstream consumer of the performance-counter array.
// - Every cfg_interval_i cycles, walks the counter array through its shared read/write port.
// - Reads each counter enabled in cfg_mask_i and pushes {idx, value, seq, last} into a FIFO.
// - The FIFO is drained over a valid/ready stream by the debug/trace sink.
// - CSR accesses to the counter port always have priority; the sampler stalls for them.

---
 rtl/perf_sample_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_perf_sample_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_sample_unit.sv
// Periodic sampler for the performance-counter array. Every interval it walks the
// counter port, captures the enabled counters and queues them for a stream sink.
module perf_sample_unit #(
  parameter int unsigned NrCounters    = 16,
  parameter int unsigned FifoDepth     = 8,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned IntervalWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     debug_mode_i,
  input  logic                     cfg_en_i,
  input  logic [IntervalWidth-1:0] cfg_interval_i,
  input  logic [NrCounters-1:0]    cfg_mask_i,
  input  logic                     csr_req_i,
  output logic                     pc_req_o,
  output logic [4:0]               pc_addr_o,
  input  logic [XLEN-1:0]          pc_data_i,
  output logic                     smp_valid_o,
  input  logic                     smp_ready_i,
  output logic [XLEN-1:0]          smp_data_o,
  output logic [4:0]               smp_idx_o,
  output logic [15:0]              smp_seq_o,
  output logic                     smp_last_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o,
  input  logic                     ovf_clr_i,
  output logic                     busy_o
);

  localparam int unsigned IdxW = (NrCounters > 1) ? $clog2(NrCounters) : 1;
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StScan} state_e;

  state_e                   state_q, state_d;
  logic [IntervalWidth-1:0] timer_q, timer_d;
  logic [4:0]               idx_q, idx_d;
  logic [15:0]              seq_q, seq_d;
  logic [NrCounters-1:0]    mask_q, mask_d;
  logic                     pend_q, pend_d;
  logic                     ovf_q, ovf_d;
  logic [15:0]              drop_q, drop_d;

  logic [PtrW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]          cnt_q;
  logic [XLEN-1:0]          data_mem [FifoDepth];
  logic [4:0]               idx_mem  [FifoDepth];
  logic [15:0]              seq_mem  [FifoDepth];
  logic                     last_mem [FifoDepth];

  logic                     tick;
  logic                     timer_hit;
  logic                     exp_now;
  logic [IntervalWidth-1:0] interval_m1;
  logic [IdxW-1:0]          idx_sel;
  logic                     pc_req;
  logic                     push;
  logic                     last;
  logic                     full;
  logic                     pop;
  logic                     do_push;
  logic                     drop;

  // An interval of 0 behaves like 1 (scan every cycle it can).
  assign interval_m1 = (cfg_interval_i == '0) ? '0 : cfg_interval_i - IntervalWidth'(1);
  assign timer_hit   = (timer_q == interval_m1);
  assign tick        = ~debug_mode_i;
  assign idx_sel     = idx_q[IdxW-1:0];

  // Current sample is the last of its scan when no higher mask bit is set.
  always_comb begin
    last = 1'b1;
    for (int unsigned i = 0; i < NrCounters; i++) begin
      if (mask_q[i] && (i > 32'(idx_q))) last = 1'b0;
    end
  end

  // Scan FSM next-state, interval timer and counter-port request.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    seq_d   = seq_q;
    mask_d  = mask_q;
    pend_d  = pend_q;
    pc_req  = 1'b0;
    push    = 1'b0;
    exp_now = 1'b0;
    if (!cfg_en_i) begin
      // Disable wins from any state; a partial scan is simply abandoned.
      state_d = StIdle;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWait;
          timer_d = '0;
        end
        StWait: begin
          if (tick) begin
            if (timer_hit) begin
              state_d = StScan;
              timer_d = '0;
              idx_d   = '0;
              mask_d  = cfg_mask_i;
            end else begin
              timer_d = timer_q + IntervalWidth'(1);
            end
          end
        end
        StScan: begin
          // Timer keeps running so intervals are measured start-to-start.
          exp_now = tick & timer_hit;
          if (tick) timer_d = timer_hit ? '0 : timer_q + IntervalWidth'(1);
          if (exp_now) pend_d = 1'b1;
          if (!csr_req_i) begin
            if (mask_q[idx_sel]) begin
              pc_req = 1'b1;
              push   = 1'b1;
            end
            idx_d = idx_q + 5'd1;
            if (idx_q == 5'(NrCounters - 1)) begin
              seq_d = seq_q + 16'd1;
              if (pend_q || exp_now) begin
                // Expiry seen during this scan: start the next one straight away.
                idx_d  = '0;
                mask_d = cfg_mask_i;
                pend_d = 1'b0;
              end else begin
                state_d = StWait;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM and scan bookkeeping registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      timer_q <= '0;
      idx_q   <= '0;
      seq_q   <= '0;
      mask_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      seq_q   <= seq_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
    end
  end

  // Full is judged before the same-cycle pop, so a push into a full FIFO drops.
  assign full    = (cnt_q == CntW'(FifoDepth));
  assign pop     = smp_valid_o & smp_ready_i;
  assign do_push = push & ~full;
  assign drop    = push & full;

  // Overflow flag and saturating drop counter; a same-cycle drop beats the clear.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (ovf_clr_i) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_d != 16'hFFFF) drop_d = drop_d + 16'd1;
    end
  end

  // FIFO pointers, occupancy and overflow state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (pop && !do_push) begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end
  end

  // FIFO storage; contents are only visible through the valid-gated outputs.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      data_mem[wr_ptr_q] <= pc_data_i;
      idx_mem[wr_ptr_q]  <= idx_q;
      seq_mem[wr_ptr_q]  <= seq_q;
      last_mem[wr_ptr_q] <= last;
    end
  end

  assign pc_req_o    = pc_req;
  assign pc_addr_o   = pc_req ? idx_q : 5'd0;
  assign busy_o      = (state_q == StScan);
  assign smp_valid_o = (cnt_q != '0);
  assign smp_data_o  = smp_valid_o ? data_mem[rd_ptr_q] : '0;
  assign smp_idx_o   = smp_valid_o ? idx_mem[rd_ptr_q] : '0;
  assign smp_seq_o   = smp_valid_o ? seq_mem[rd_ptr_q] : '0;
  assign smp_last_o  = smp_valid_o & last_mem[rd_ptr_q];
  assign overflow_o  = ovf_q;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_perf_sample_unit.sv
// Bench for perf_sample_unit: directed scenarios plus randomized scans, all checked
// cycle by cycle against a sample-queue model built from the sampling rules.
module tb_perf_sample_unit;
  localparam int NC = 16;
  localparam int FD = 8;
  localparam int XL = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dbg, en, csr, ready, clr;
  logic [IW-1:0] interval;
  logic [NC-1:0] mask;
  logic [XL-1:0] pc_data;
  logic          pc_req, smp_valid, smp_last, overflow, busy;
  logic [4:0]    pc_addr, smp_idx;
  logic [XL-1:0] smp_data;
  logic [15:0]   smp_seq, drop_cnt;

  logic [XL-1:0] ctr [NC];

  always #5 clk = ~clk;
  assign pc_data = ctr[pc_addr[3:0]];

  perf_sample_unit #(.NrCounters(NC), .FifoDepth(FD), .XLEN(XL), .IntervalWidth(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .debug_mode_i(dbg), .cfg_en_i(en),
    .cfg_interval_i(interval), .cfg_mask_i(mask), .csr_req_i(csr),
    .pc_req_o(pc_req), .pc_addr_o(pc_addr), .pc_data_i(pc_data),
    .smp_valid_o(smp_valid), .smp_ready_i(ready), .smp_data_o(smp_data),
    .smp_idx_o(smp_idx), .smp_seq_o(smp_seq), .smp_last_o(smp_last),
    .overflow_o(overflow), .drop_cnt_o(drop_cnt), .ovf_clr_i(clr), .busy_o(busy)
  );

  typedef struct packed {
    logic [4:0]    idx;
    logic [XL-1:0] val;
    logic [15:0]   seq;
    logic          last;
  } smp_t;

  smp_t        mq[$];
  bit          m_ovf;
  int          m_drop;
  logic [15:0] m_seq;
  int          total, bad, cyc;
  int          e_next;   // next timer expiry cycle not yet consumed by a scan
  int          ival;     // effective interval
  bit          rnd_ready;
  int          len;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle's outputs, then advance the sample-queue model across the edge.
  task automatic step(input bit e_req, input logic [4:0] e_addr, input bit e_busy,
                      input bit push, input smp_t ent);
    bit full, pop;
    if (rnd_ready) ready = 1'($urandom_range(0, 1));
    #1;
    chk("pc_req", 128'(pc_req), 128'(e_req));
    chk("pc_addr", 128'(pc_addr), 128'(e_addr));
    chk("busy", 128'(busy), 128'(e_busy));
    chk("valid", 128'(smp_valid), 128'(mq.size() != 0));
    if (mq.size() != 0) chk("head", 128'({smp_idx, smp_data, smp_seq, smp_last}), 128'(mq[0]));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    full = (mq.size() == FD);
    pop  = (mq.size() != 0) && ready;
    if (clr) begin m_ovf = 0; m_drop = 0; end
    if (push && full) begin m_ovf = 1; if (m_drop < 65535) m_drop++; end
    if (pop) void'(mq.pop_front());
    if (push && !full) mq.push_back(ent);
    cyc++;
    @(negedge clk);
  endtask

  task automatic quiet_step(input bit e_busy);
    step(1'b0, 5'd0, e_busy, 1'b0, '0);
  endtask

  task automatic check_zero();
    chk("rst_pc_req", 128'(pc_req), 128'(0));
    chk("rst_pc_addr", 128'(pc_addr), 128'(0));
    chk("rst_valid", 128'(smp_valid), 128'(0));
    chk("rst_data", 128'({smp_idx, smp_data, smp_seq, smp_last}), 128'(0));
    chk("rst_ovf", 128'({overflow, drop_cnt}), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
  endtask

  task automatic fill_ctr();
    for (int i = 0; i < NC; i++) ctr[i] = {$urandom(), $urandom()};
  endtask

  // Enable from IDLE; the first expiry lands after ival WAIT cycles.
  task automatic start(input int iv);
    interval = iv;
    ival = (iv == 0) ? 1 : iv;
    en = 1'b1;
    e_next = cyc + ival;
    quiet_step(1'b0);
  endtask

  // Disable; if an expiry is pending the DUT is already in a new scan.
  task automatic stop();
    en = 1'b0;
    quiet_step(e_next < cyc);
  endtask

  task automatic drain(input int n);
    rnd_ready = 0;
    ready = 1'b1;
    repeat (n) quiet_step(1'b0);
  endtask

  // One scan. mode: 0 no CSR, 1 random CSR stalls, 2 three stalls at index 2.
  // abort_at >= 0 interrupts the scan at that index (by disable or by reset).
  task automatic do_scan(input int mode, input int abort_at, input bit by_rst, output int n);
    int   i;
    int   stalls;
    bit   b;
    smp_t e;
    i = 0; stalls = 0; n = 0;
    while (i < NC) begin
      csr = 1'b0;
      if (mode == 1 && stalls < 8) csr = ($urandom_range(0, 3) == 0);
      if (mode == 2 && i == 2 && stalls < 3) csr = 1'b1;
      if (i == abort_at) begin
        if (by_rst) begin
          rst_n = 1'b0;
          #1;
          check_zero();
          mq.delete(); m_ovf = 0; m_drop = 0; m_seq = '0;
          en = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          cyc++;
        end else begin
          en = 1'b0;
          quiet_step(1'b1);
        end
        n++;
        return;
      end
      if (csr) begin
        stalls++;
        quiet_step(1'b1);
      end else begin
        b      = mask[i];
        e.idx  = 5'(i);
        e.val  = ctr[i];
        e.seq  = m_seq;
        e.last = ((mask >> (i + 1)) == '0);
        step(b, b ? 5'(i) : 5'd0, 1'b1, b, e);
        i++;
      end
      n++;
    end
    csr = 1'b0;
    m_seq++;
  endtask

  // Wait for (or take the pending) expiry, then enter the scan.
  task automatic to_scan_start();
    if (e_next >= cyc) begin
      while (cyc < e_next + 1) quiet_step(1'b0);
      e_next += ival;
    end else begin
      // Only one expiry can be pending; later ones inside the same scan are lost.
      while (e_next < cyc) e_next += ival;
    end
  endtask

  task automatic run_scans(input int k, input int mode);
    for (int s = 0; s < k; s++) begin
      to_scan_start();
      do_scan(mode, -1, 1'b0, len);
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; m_seq = '0; m_ovf = 0; m_drop = 0; rnd_ready = 0;
    dbg = 0; en = 0; csr = 0; ready = 1; clr = 0; interval = '0; mask = '0;
    fill_ctr();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_zero();
    @(negedge clk);
    rst_n = 1'b1;
    quiet_step(1'b0);

    // Sparse mask, interval shorter than a scan: back-to-back scans with seq stepping.
    mask = 16'h0005;
    start(10);
    run_scans(3, 0);
    stop();
    drain(6);

    // Three CSR stall cycles at index 2.
    fill_ctr();
    mask = 16'hFFFF;
    start(25);
    run_scans(1, 2);
    stop();
    drain(20);

    // Sink stalled: FIFO fills with idx0..7, the rest drop; then clear and drain.
    fill_ctr();
    ready = 1'b0;
    start(100);
    run_scans(1, 0);
    stop();
    quiet_step(1'b0);
    clr = 1'b1;
    quiet_step(1'b0);
    clr = 1'b0;
    drain(12);

    // Disable at index 5: five samples, no last, seq untouched.
    fill_ctr();
    start(30);
    to_scan_start();
    do_scan(0, 5, 1'b0, len);
    drain(10);

    // Debug freezes the WAIT timer for 4 cycles.
    mask = 16'h0003;
    start(10);
    dbg = 1'b1;
    repeat (4) quiet_step(1'b0);
    dbg = 1'b0;
    e_next += 4;
    run_scans(1, 0);
    stop();
    drain(6);

    // Reset in the middle of a scan with a non-empty FIFO; seq restarts at 0.
    fill_ctr();
    mask = 16'hFFFF;
    ready = 1'b0;
    start(12);
    to_scan_start();
    do_scan(0, 6, 1'b1, len);
    ready = 1'b1;
    quiet_step(1'b0);
    start(20);
    run_scans(2, 0);
    stop();
    drain(12);

    // Randomized masks, intervals (including 0), CSR stalls and sink backpressure.
    for (int r = 0; r < 6; r++) begin
      fill_ctr();
      mask = 16'($urandom());
      rnd_ready = 1;
      start(int'($urandom_range(0, 40)));
      run_scans(3, 1);
      stop();
      drain(12);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
